cpu64_hazard_ctrl: RTL

Central pipeline hazard controller for the 4-stage cpu64 core (IF=0, ID=1, EX=2, MEM=3).
- Detects load-use hazards, multi-cycle EX ops, data-cache stalls, branch redirects and traps.
- Drives per-stage stall/bubble/squash vectors directly into each stage's validity tracker, so it sits immediately upstream of those trackers.
- Contains a small FSM to stretch load-use bubbles and hold the post-trap fetch flush.

---
 rtl/cpu64_hazard_ctrl.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/cpu64_hazard_ctrl.sv
// Pipeline hazard controller for the 4-stage cpu64 core: load-use, multi-cycle EX, dcache stall,
// redirect and trap handling. Optional perf counters are enabled with CPU64_HAZARD_PERF_EN.
module cpu64_hazard_ctrl #(
    parameter int LOAD_USE_CYCLES = 1,
    parameter int FLUSH_CYCLES    = 2,
    parameter int REG_ADDR_W      = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  id_valid_i,
    input  logic                  id_rs1_used_i,
    input  logic                  id_rs2_used_i,
    input  logic [REG_ADDR_W-1:0] id_rs1_addr_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_addr_i,
    input  logic                  ex_valid_i,
    input  logic                  ex_is_load_i,
    input  logic [REG_ADDR_W-1:0] ex_rd_addr_i,
    input  logic                  ex_busy_i,
    input  logic                  mem_stall_i,
    input  logic                  redirect_i,
    input  logic                  trap_i,
    output logic [3:0]            stall_o,
    output logic [3:0]            bubble_o,
    output logic [3:0]            squash_o,
    output logic                  lu_hazard_o
`ifdef CPU64_HAZARD_PERF_EN
    ,
    output logic [31:0]           perf_stall_cnt_o,
    output logic [31:0]           perf_bubble_cnt_o
`endif
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_LU    = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t     state_r;
    state_t     state_nxt_s;
    logic [3:0] cnt_r;
    logic [3:0] cnt_nxt_s;
    logic       hazard_s;
    logic       lu_active_s;

    // Raw load-use detect; x0 is hardwired zero and never creates a dependency
    always_comb begin
        hazard_s = id_valid_i & ex_valid_i & ex_is_load_i
                 & (ex_rd_addr_i != {REG_ADDR_W{1'b0}})
                 & ((id_rs1_used_i & (id_rs1_addr_i == ex_rd_addr_i))
                  | (id_rs2_used_i & (id_rs2_addr_i == ex_rd_addr_i)));
    end

    // Load-use bubble is held off by any higher-priority event that cycle
    always_comb begin
        lu_active_s = ((state_r == ST_RUN) & hazard_s) | (state_r == ST_LU);
        if (mem_stall_i | ex_busy_i | redirect_i | trap_i) begin
            lu_active_s = 1'b0;
        end else begin
            lu_active_s = lu_active_s;
        end
    end

    // Zero-latency per-stage control vectors, forced quiet while in reset
    always_comb begin
        stall_o     = 4'b0000;
        bubble_o    = 4'b0000;
        squash_o    = 4'b0000;
        lu_hazard_o = 1'b0;
        if (rst_i) begin
            stall_o = 4'b0000;
        end else if (trap_i) begin
            squash_o    = 4'b1111;
            lu_hazard_o = hazard_s;
        end else begin
            lu_hazard_o = hazard_s;
            if (mem_stall_i) begin
                stall_o = stall_o | 4'b1111;
            end else if (ex_busy_i) begin
                stall_o  = stall_o | 4'b0111;
                bubble_o = bubble_o | 4'b1000;
            end else begin
                stall_o = stall_o;
            end
            if (redirect_i) begin
                squash_o = squash_o | 4'b0011;
            end else begin
                squash_o = squash_o;
            end
            if (lu_active_s) begin
                stall_o  = stall_o | 4'b0011;
                bubble_o = bubble_o | 4'b0100;
            end else begin
                bubble_o = bubble_o;
            end
            if (state_r == ST_FLUSH) begin
                bubble_o = bubble_o | 4'b0001;
            end else begin
                bubble_o = bubble_o;
            end
        end
    end

    // Next-state: trap > redirect > mem_stall > normal progression
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        if (trap_i) begin
            state_nxt_s = ST_FLUSH;
            cnt_nxt_s   = 4'(FLUSH_CYCLES);
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (hazard_s & ~redirect_i & ~mem_stall_i & ~ex_busy_i
                        & (LOAD_USE_CYCLES > 1)) begin
                        state_nxt_s = ST_LU;
                        cnt_nxt_s   = 4'(LOAD_USE_CYCLES - 1);
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end
                ST_LU: begin
                    if (redirect_i) begin
                        state_nxt_s = ST_RUN;
                        cnt_nxt_s   = 4'd0;
                    end else if (mem_stall_i | ex_busy_i) begin
                        cnt_nxt_s = cnt_r;
                    end else if (cnt_r <= 4'd1) begin
                        state_nxt_s = ST_RUN;
                        cnt_nxt_s   = 4'd0;
                    end else begin
                        cnt_nxt_s = cnt_r - 4'd1;
                    end
                end
                ST_FLUSH: begin
                    // The vector fetch proceeds regardless of redirects or data stalls
                    if (cnt_r <= 4'd1) begin
                        state_nxt_s = ST_RUN;
                        cnt_nxt_s   = 4'd0;
                    end else begin
                        cnt_nxt_s = cnt_r - 4'd1;
                    end
                end
                default: begin
                    state_nxt_s = ST_RUN;
                    cnt_nxt_s   = 4'd0;
                end
            endcase
        end
    end

    // State and countdown registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= ST_RUN;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

`ifdef CPU64_HAZARD_PERF_EN
    logic [31:0] perf_stall_r;
    logic [31:0] perf_bubble_r;

    // Saturating occupancy counters for stall and bubble cycles
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            perf_stall_r  <= 32'd0;
            perf_bubble_r <= 32'd0;
        end else begin
            if ((|stall_o) && (perf_stall_r != 32'hFFFF_FFFF)) begin
                perf_stall_r <= perf_stall_r + 32'd1;
            end else begin
                perf_stall_r <= perf_stall_r;
            end
            if ((|bubble_o) && (perf_bubble_r != 32'hFFFF_FFFF)) begin
                perf_bubble_r <= perf_bubble_r + 32'd1;
            end else begin
                perf_bubble_r <= perf_bubble_r;
            end
        end
    end

    assign perf_stall_cnt_o  = perf_stall_r;
    assign perf_bubble_cnt_o = perf_bubble_r;
`endif

endmodule
